// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Complete-stage arbiter between the functional units and the common data
// bus. Each FU owns a one-entry holding buffer for its finished result
// (destination tag + value). Every cycle at most one buffered result is
// chosen round-robin and broadcast on the registered CDB outputs, which feed
// the reservation stations, the map table and the ROB.
//
// Parameters
//   NUM_FU  number of functional units / holding buffers
//   T_W     physical register tag width
//   D_W     result data width
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   en           global stall; when low every register holds
//   squash       synchronous mispredict flush of all buffered results
//   fu_valid     per-FU "result presented this cycle"
//   fu_T_idx     packed destination tags, slice i = [i*T_W +: T_W]
//   fu_result    packed result values,   slice i = [i*D_W +: D_W]
//   fu_free      per-FU "buffer can accept a result this cycle"
//   complete_en  CDB carries a valid broadcast
//   CDB_T        broadcast tag
//   CDB_value    broadcast value
//   CDB_grant    one-hot source FU of the current broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int T_W    = 6,
    parameter int D_W    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  squash,
    input  logic [NUM_FU-1:0]     fu_valid,
    input  logic [NUM_FU*T_W-1:0] fu_T_idx,
    input  logic [NUM_FU*D_W-1:0] fu_result,
    output logic [NUM_FU-1:0]     fu_free,
    output logic                  complete_en,
    output logic [T_W-1:0]        CDB_T,
    output logic [D_W-1:0]        CDB_value,
    output logic [NUM_FU-1:0]     CDB_grant
);

    // A single-FU build still needs a one-bit pointer.
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_FU-1:0] buf_valid;
    logic [T_W-1:0]    buf_T   [NUM_FU];
    logic [D_W-1:0]    buf_val [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr;

    // -------------------------------------------------------------------------
    // Combinational arbitration signals
    // -------------------------------------------------------------------------
    logic [NUM_FU-1:0] grant;
    logic [PTR_W-1:0]  win_idx;
    logic              found;
    logic [PTR_W:0]    scan;
    logic [NUM_FU-1:0] accept;
    logic              active;
    logic [PTR_W-1:0]  rr_next;

    // Arbitration and capture are both suppressed while stalled or flushing.
    assign active = en && !squash;

    // Round-robin pick: walk the buffers starting at rr_ptr, wrapping modulo
    // NUM_FU, and grant the first full one. The scan index is one bit wider
    // than the pointer so the wrap can be done with a single subtraction
    // instead of a modulo operator.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        scan    = '0;
        if (active) begin
            for (int k = 0; k < NUM_FU; k++) begin
                scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (scan >= (PTR_W+1)'(NUM_FU)) begin
                    scan = scan - (PTR_W+1)'(NUM_FU);
                end
                if (!found && buf_valid[scan[PTR_W-1:0]]) begin
                    found                  = 1'b1;
                    grant[scan[PTR_W-1:0]] = 1'b1;
                    win_idx                = scan[PTR_W-1:0];
                end
            end
        end
    end

    // A buffer being drained this cycle counts as free, which lets an FU
    // hand over a new result on the very edge its previous one is broadcast.
    assign fu_free = active ? (~buf_valid | grant) : '0;

    // Results presented while the buffer is busy are dropped here, so a
    // misbehaving FU can never overwrite a result still waiting for the CDB.
    assign accept = fu_valid & fu_free;

    // Pointer moves to the slot just after the winner so it has the lowest
    // priority next time.
    assign rr_next = (win_idx == PTR_W'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;

    // -------------------------------------------------------------------------
    // Control state: buffer valid bits, round-robin pointer and CDB outputs.
    // A squash empties every buffer and silences the CDB but leaves the last
    // broadcast tag/value in place, since nothing downstream looks at them
    // while complete_en is low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid   <= '0;
            rr_ptr      <= '0;
            complete_en <= 1'b0;
            CDB_T       <= '0;
            CDB_value   <= '0;
            CDB_grant   <= '0;
        end else if (en) begin
            if (squash) begin
                buf_valid   <= '0;
                rr_ptr      <= '0;
                complete_en <= 1'b0;
                CDB_grant   <= '0;
            end else begin
                // Capture wins over the drain so a same-edge refill keeps
                // the buffer full with the new result.
                buf_valid   <= (buf_valid & ~grant) | accept;
                complete_en <= found;
                CDB_grant   <= grant;
                if (found) begin
                    CDB_T     <= buf_T[win_idx];
                    CDB_value <= buf_val[win_idx];
                    rr_ptr    <= rr_next;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Buffer payloads. These carry no reset: their contents only matter while
    // the matching buf_valid bit is set, and that bit is reset above.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                buf_T[i]   <= fu_T_idx[i*T_W +: T_W];
                buf_val[i] <= fu_result[i*D_W +: D_W];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter. Expected broadcasts are pushed to a
// scoreboard queue when the FU results are driven; a monitor pops one entry
// for every broadcast the DUT makes and compares tag, value and grant.
// Directed checks cover reset values, latency, flush, stall and async reset.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_FU = 5;
    localparam int T_W    = 6;
    localparam int D_W    = 64;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  en;
    logic                  squash;
    logic [NUM_FU-1:0]     fu_valid;
    logic [NUM_FU*T_W-1:0] fu_T_idx;
    logic [NUM_FU*D_W-1:0] fu_result;
    logic [NUM_FU-1:0]     fu_free;
    logic                  complete_en;
    logic [T_W-1:0]        CDB_T;
    logic [D_W-1:0]        CDB_value;
    logic [NUM_FU-1:0]     CDB_grant;

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .T_W    (T_W),
        .D_W    (D_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .squash      (squash),
        .fu_valid    (fu_valid),
        .fu_T_idx    (fu_T_idx),
        .fu_result   (fu_result),
        .fu_free     (fu_free),
        .complete_en (complete_en),
        .CDB_T       (CDB_T),
        .CDB_value   (CDB_value),
        .CDB_grant   (CDB_grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [T_W-1:0]    tag;
        logic [D_W-1:0]    value;
        logic [NUM_FU-1:0] grant;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    logic [T_W-1:0] stim_T   [NUM_FU];
    logic [D_W-1:0] stim_val [NUM_FU];
    logic           last_en = 1'b0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [D_W-1:0] mkval(input int tag);
        return 64'hC0DE_0000_0000_0000 | (64'(tag) << 16) | 64'(tag);
    endfunction

    task automatic pushExp(input int tag, input logic [D_W-1:0] value, input int fu);
        exp_t e;
        e.tag   = T_W'(tag);
        e.value = value;
        e.grant = NUM_FU'(1) << fu;
        exp_q.push_back(e);
    endtask

    task automatic setFu(input int fu, input int tag, input logic [D_W-1:0] value);
        stim_T[fu]   = T_W'(tag);
        stim_val[fu] = value;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Present the staged results on the FUs in mask for exactly one edge.
    task automatic applyStimulus(input logic [NUM_FU-1:0] mask);
        for (int i = 0; i < NUM_FU; i++) begin
            fu_T_idx[i*T_W +: T_W]  = stim_T[i];
            fu_result[i*D_W +: D_W] = stim_val[i];
        end
        fu_valid = mask;
        nextCycle();
        fu_valid = '0;
    endtask

    // Wait (bounded) for every expected broadcast, then idle a few cycles so
    // any surplus broadcast is caught by the monitor.
    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            nextCycle();
            n++;
        end
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) nextCycle();
    endtask

    // A new broadcast is one seen after an edge taken with en high.
    always @(posedge clock) last_en <= en;

    always @(negedge clock) begin
        if (reset === 1'b1 && complete_en === 1'b1 && last_en === 1'b1) begin
            checkOutput("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("cdb_T", 64'(CDB_T), 64'(mon_e.tag));
                checkOutput("cdb_value", CDB_value, mon_e.value);
                checkOutput("cdb_grant", 64'(CDB_grant), 64'(mon_e.grant));
            end
        end
    end

    // FU protocol: a result may only be presented when its buffer is free.
    always @(negedge clock) begin
        if (reset === 1'b1 && fu_valid != '0) begin
            checkOutput("fu_free_ok", 64'(fu_valid & fu_free), 64'(fu_valid));
            assert ((fu_valid & ~fu_free) == '0)
                else $error("[TB] protocol violation fu_valid=%b fu_free=%b", fu_valid, fu_free);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b0;
        en        = 1'b1;
        squash    = 1'b0;
        fu_valid  = '0;
        fu_T_idx  = '0;
        fu_result = '0;
        for (int i = 0; i < NUM_FU; i++) setFu(i, 0, '0);

        // Reset values.
        #3;
        checkOutput("rst_complete_en", 64'(complete_en), 64'd0);
        checkOutput("rst_CDB_T", 64'(CDB_T), 64'd0);
        checkOutput("rst_CDB_value", CDB_value, 64'd0);
        checkOutput("rst_CDB_grant", 64'(CDB_grant), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checkOutput("free_after_rst", 64'(fu_free), 64'h1F);
        nextCycle();

        // Single result on FU2: two-edge latency, one-cycle broadcast.
        $display("[TB] single result latency");
        setFu(2, 17, 64'hDEAD);
        pushExp(17, 64'hDEAD, 2);
        applyStimulus(5'b00100);
        @(negedge clock);
        checkOutput("lat_edge0", 64'(complete_en), 64'd0);
        checkOutput("lat_free", 64'(fu_free), 64'h1F);
        nextCycle();
        @(negedge clock);
        checkOutput("lat_edge1", 64'(complete_en), 64'd1);
        nextCycle();
        @(negedge clock);
        checkOutput("one_cycle_bcast", 64'(complete_en), 64'd0);
        nextCycle();

        // rr_ptr is now 3: FU4 must beat FU1.
        $display("[TB] pointer after FU2 grant");
        setFu(1, 20, mkval(20));
        setFu(4, 21, mkval(21));
        pushExp(21, mkval(21), 4);
        pushExp(20, mkval(20), 1);
        applyStimulus(5'b10010);
        drain(10);

        // All five FUs at once from a fresh reset.
        $display("[TB] all FUs contend");
        reset = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < NUM_FU; i++) begin
            setFu(i, 10 + i, mkval(10 + i));
            pushExp(10 + i, mkval(10 + i), i);
        end
        applyStimulus(5'b11111);
        for (int k = 0; k < NUM_FU; k++) begin
            @(negedge clock);
            checkOutput("free_while_draining", 64'(fu_free), 64'((2 << k) - 1));
            nextCycle();
        end
        drain(10);

        // Same-edge drain and refill on FU0 (rr_ptr = 0).
        $display("[TB] back-to-back refill");
        setFu(0, 3, mkval(3));
        pushExp(3, mkval(3), 0);
        pushExp(4, mkval(4), 0);
        applyStimulus(5'b00001);
        setFu(0, 4, mkval(4));
        applyStimulus(5'b00001);
        @(negedge clock);
        checkOutput("refill_first_T", 64'(CDB_T), 64'd3);
        nextCycle();
        @(negedge clock);
        checkOutput("refill_no_bubble", 64'(complete_en), 64'd1);
        checkOutput("refill_second_T", 64'(CDB_T), 64'd4);
        drain(10);

        // Fairness: FU1 and FU3 refill right after every grant (rr_ptr = 1).
        $display("[TB] fairness FU1/FU3");
        for (int j = 1; j <= 10; j++) begin
            if (j % 2 == 1) pushExp(30 + (j - 1) / 2, mkval(30 + (j - 1) / 2), 1);
            else            pushExp(40 + (j - 2) / 2, mkval(40 + (j - 2) / 2), 3);
        end
        setFu(1, 30, mkval(30));
        setFu(3, 40, mkval(40));
        applyStimulus(5'b01010);
        for (int j = 1; j <= 8; j++) begin
            if (j % 2 == 1) begin
                setFu(1, 30 + (j + 1) / 2, mkval(30 + (j + 1) / 2));
                applyStimulus(5'b00010);
            end else begin
                setFu(3, 40 + j / 2, mkval(40 + j / 2));
                applyStimulus(5'b01000);
            end
        end
        drain(10);

        // Squash with buffers 0, 2, 4 full: nothing may be broadcast.
        $display("[TB] squash");
        setFu(0, 50, mkval(50));
        setFu(2, 51, mkval(51));
        setFu(4, 52, mkval(52));
        applyStimulus(5'b10101);
        squash = 1'b1;
        @(negedge clock);
        checkOutput("squash_free_low", 64'(fu_free), 64'd0);
        nextCycle();
        squash = 1'b0;
        @(negedge clock);
        checkOutput("squash_ce", 64'(complete_en), 64'd0);
        checkOutput("squash_free", 64'(fu_free), 64'h1F);
        repeat (6) nextCycle();

        // Stall while tag 9 is on the CDB; rr_ptr = 4 must survive it.
        $display("[TB] stall");
        setFu(3, 9, mkval(9));
        pushExp(9, mkval(9), 3);
        applyStimulus(5'b01000);
        setFu(0, 60, mkval(60));
        setFu(4, 61, mkval(61));
        pushExp(61, mkval(61), 4);
        pushExp(60, mkval(60), 0);
        applyStimulus(5'b10001);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("stall_ce", 64'(complete_en), 64'd1);
            checkOutput("stall_T", 64'(CDB_T), 64'd9);
            checkOutput("stall_grant", 64'(CDB_grant), 64'h08);
            checkOutput("stall_free", 64'(fu_free), 64'd0);
            nextCycle();
        end
        en = 1'b1;
        drain(10);

        // Async reset pulse in the middle of a broadcast; FU2's result is lost.
        $display("[TB] async reset mid-broadcast");
        setFu(1, 7, mkval(7));
        setFu(2, 8, mkval(8));
        pushExp(7, mkval(7), 1);
        applyStimulus(5'b00110);
        nextCycle();
        @(negedge clock);
        #1;
        checkOutput("pre_rst_ce", 64'(complete_en), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("async_rst_ce", 64'(complete_en), 64'd0);
        checkOutput("async_rst_grant", 64'(CDB_grant), 64'd0);
        checkOutput("async_rst_T", 64'(CDB_T), 64'd0);
        #1 reset = 1'b1;
        repeat (6) nextCycle();
        @(negedge clock);
        checkOutput("post_rst_free", 64'(fu_free), 64'h1F);
        checkOutput("sb_final", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
